// File: rtl/boot_bus_arbiter.sv
// Memory bus owner across boot: copies the bootloader image into RAM, holds the CPU in reset, then hands over.
// Define BOOT_WP_EN to block CPU writes at or above WP_BASE once the CPU owns the bus.
module boot_bus_arbiter #(
    parameter int          RELEASE_CYCLES = 16,
    parameter int          BREAK_HOLD     = 32000000,
    parameter logic [15:0] WP_BASE        = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        booting,
    input  logic [15:0] boot_address,
    input  logic [7:0]  boot_data,
    output logic        reboot_request,
    input  logic        break_key,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_reset,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_din,
    output logic        mem_we
);

    // state      | meaning
    // S_WAITBOOT | CPU in reset, bus to bootloader, waiting for booting
    // S_BOOT     | bootloader streaming image bytes into RAM
    // S_RELEASE  | image done, counting down before releasing the CPU
    // S_RUN      | CPU owns the bus; long BREAK press requests a reboot
    typedef enum logic [1:0] {
        S_WAITBOOT,
        S_BOOT,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam logic [7:0]  REL_LOAD = 8'(RELEASE_CYCLES - 1);
    localparam logic [25:0] HOLD_TC  = 26'(BREAK_HOLD - 1);
`ifdef BOOT_WP_EN
    localparam logic WP_ENABLE = 1'b1;
`else
    localparam logic WP_ENABLE = 1'b0;
`endif

    state_t      state, state_next;
    logic [7:0]  rel_cnt, rel_cnt_next;
    logic [25:0] hold_cnt;
    logic        break_meta, break_sync;
    logic        hold_hit;
    logic        bus_cpu;
    logic        wp_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_WAITBOOT;
            rel_cnt <= '0;
        end else begin
            state   <= state_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        rel_cnt_next = rel_cnt;
        case (state)
            S_WAITBOOT: begin
                if (booting) state_next = S_BOOT;
            end
            S_BOOT: begin
                if (!booting) begin
                    rel_cnt_next = REL_LOAD;
                    state_next   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (booting) begin
                    state_next = S_BOOT;
                end else if (rel_cnt == 8'd0) begin
                    state_next = S_RUN;
                end else begin
                    rel_cnt_next = rel_cnt - 8'd1;
                end
            end
            S_RUN: begin
                if (reboot_request) state_next = S_WAITBOOT;
            end
            default: state_next = S_WAITBOOT;
        endcase
    end

    // The pulse is registered, so it lands BREAK_HOLD cycles after the first synchronised-high cycle.
    assign hold_hit = (state == S_RUN) && break_sync && (hold_cnt == HOLD_TC);

    always_ff @(posedge clk) begin
        if (reset) begin
            break_meta     <= 1'b0;
            break_sync     <= 1'b0;
            hold_cnt       <= '0;
            reboot_request <= 1'b0;
        end else begin
            break_meta     <= break_key;
            break_sync     <= break_meta;
            reboot_request <= hold_hit;
            if ((state != S_RUN) || !break_sync || hold_hit || reboot_request)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + 26'd1;
        end
    end

    assign bus_cpu     = (state == S_RUN);
    assign cpu_reset   = !bus_cpu;
    assign mem_address = bus_cpu ? cpu_address : boot_address;
    assign mem_din     = bus_cpu ? cpu_dout : boot_data;
    assign wp_block    = WP_ENABLE && (cpu_address >= WP_BASE);

    always_comb begin
        mem_we = 1'b0;
        case (state)
            S_WAITBOOT, S_BOOT: mem_we = booting;
            S_RELEASE:          mem_we = 1'b0;
            S_RUN:              mem_we = cpu_we && !wp_block;
            default:            mem_we = 1'b0;
        endcase
        if (reset) mem_we = 1'b0;
    end

endmodule

// File: tb/tb_boot_bus_arbiter.sv
// Directed bench for boot_bus_arbiter: boot image load, CPU release timing, write protection, BREAK reboot.
module tb_boot_bus_arbiter;

`ifdef BOOT_WP_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        booting;
    logic [15:0] boot_address;
    logic [7:0]  boot_data;
    logic        reboot_request;
    logic        break_key;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_reset;
    logic [15:0] mem_address;
    logic [7:0]  mem_din;
    logic        mem_we;

    int passed = 0;
    int total  = 0;

    boot_bus_arbiter #(
        .RELEASE_CYCLES(16),
        .BREAK_HOLD    (10),
        .WP_BASE       (16'h8000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .booting       (booting),
        .boot_address  (boot_address),
        .boot_data     (boot_data),
        .reboot_request(reboot_request),
        .break_key     (break_key),
        .cpu_address   (cpu_address),
        .cpu_dout      (cpu_dout),
        .cpu_we        (cpu_we),
        .cpu_reset     (cpu_reset),
        .mem_address   (mem_address),
        .mem_din       (mem_din),
        .mem_we        (mem_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ca;
        logic [7:0]  cd;
        logic        cw;
        logic        bt;
        logic        ew;
        logic [15:0] ea;
        logic [7:0]  ed;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // inputs change 1 ns after the rising edge; outputs are sampled 4 ns later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller has just applied the first booting=0 cycle of S_BOOT.
    task automatic release_check(input string tag);
        for (int k = 1; k <= 17; k++) begin
            cyc();
            booting      = 1'b0;
            boot_address = 16'h0ABC;
            cpu_address  = 16'h1234;
            cpu_dout     = 8'h77;
            cpu_we       = 1'b1;
            #4;
            check({tag, "_cpu_reset"}, 32'(cpu_reset), (k < 17) ? 32'd1 : 32'd0);
            check({tag, "_bus"}, {7'd0, mem_we, mem_address, mem_din},
                  (k < 17) ? {7'd0, 1'b0, 16'h0ABC, boot_data} : {7'd0, 1'b1, 16'h1234, 8'h77});
        end
    endtask

    initial begin
        vecs[0] = '{16'h2000, 8'h55, 1'b1, 1'b0, 1'b1,   16'h2000, 8'h55};
        vecs[1] = '{16'h9000, 8'hAA, 1'b1, 1'b0, !WP_ON, 16'h9000, 8'hAA};
        vecs[2] = '{16'h7FFF, 8'hAA, 1'b1, 1'b0, 1'b1,   16'h7FFF, 8'hAA};
        vecs[3] = '{16'h8000, 8'h11, 1'b1, 1'b0, !WP_ON, 16'h8000, 8'h11};
        vecs[4] = '{16'hFFFF, 8'h22, 1'b1, 1'b0, !WP_ON, 16'hFFFF, 8'h22};
        vecs[5] = '{16'h3000, 8'h33, 1'b0, 1'b0, 1'b0,   16'h3000, 8'h33};
        vecs[6] = '{16'h4000, 8'h44, 1'b1, 1'b1, 1'b1,   16'h4000, 8'h44};
        vecs[7] = '{16'h4001, 8'h45, 1'b1, 1'b1, 1'b1,   16'h4001, 8'h45};
        vecs[8] = '{16'h4002, 8'h46, 1'b1, 1'b0, 1'b1,   16'h4002, 8'h46};

        reset        = 1'b1;
        booting      = 1'b1;
        boot_address = 16'h0000;
        boot_data    = 8'h00;
        break_key    = 1'b0;
        cpu_address  = 16'hFFFF;
        cpu_dout     = 8'h00;
        cpu_we       = 1'b1;
        cyc();
        cyc();
        #4;
        check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_reboot_req", 32'(reboot_request), 32'd0);

        cyc();
        reset   = 1'b0;
        booting = 1'b0;
        #4;
        check("idle_mem_we", 32'(mem_we), 32'd0);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // full-length boot pulse, first byte written while still in S_WAITBOOT
        for (int i = 0; i < 32'h8000; i++) begin
            cyc();
            booting      = 1'b1;
            boot_address = 16'(32'h1000 + i);
            boot_data    = 8'(i) ^ 8'hA5;
            #4;
            check("boot_write", {7'd0, mem_we, mem_address, mem_din},
                  {7'd0, 1'b1, 16'(32'h1000 + i), 8'(i) ^ 8'hA5});
            if (i % 4096 == 0) check("boot_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        cyc();
        booting = 1'b0;
        #4;
        check("boot_end_mem_we", 32'(mem_we), 32'd0);
        release_check("rel1");

        // S_RUN write vectors, including booting raised without a reboot request
        for (int v = 0; v < 9; v++) begin
            cyc();
            cpu_address  = vecs[v].ca;
            cpu_dout     = vecs[v].cd;
            cpu_we       = vecs[v].cw;
            booting      = vecs[v].bt;
            boot_address = 16'hBEEF;
            boot_data    = 8'hEE;
            #4;
            check($sformatf("run_vec%0d", v), {7'd0, mem_we, mem_address, mem_din},
                  {7'd0, vecs[v].ew, vecs[v].ea, vecs[v].ed});
            check($sformatf("run_vec%0d_cpu_reset", v), 32'(cpu_reset), 32'd0);
        end

        // BREAK held 9 synchronised cycles: no reboot
        for (int k = 0; k < 16; k++) begin
            cyc();
            cpu_we    = 1'b0;
            break_key = (k < 9);
            #4;
            check("break9_reboot_req", 32'(reboot_request), 32'd0);
            check("break9_cpu_reset", 32'(cpu_reset), 32'd0);
        end

        // BREAK held 12 cycles: pulse 10 cycles after the synchronised rise (2 cycles after the key edge)
        for (int k = 0; k < 22; k++) begin
            cyc();
            break_key = (k < 12);
            #4;
            check($sformatf("break12_rr_k%0d", k), 32'(reboot_request), (k == 12) ? 32'd1 : 32'd0);
            check($sformatf("break12_cr_k%0d", k), 32'(cpu_reset), (k >= 13) ? 32'd1 : 32'd0);
        end
        check("waitboot_bus", {15'd0, mem_address, mem_din}, {15'd0, boot_address, boot_data});

        // reboot, then booting reasserts 3 cycles into S_RELEASE
        for (int i = 0; i < 5; i++) begin
            cyc();
            booting      = 1'b1;
            boot_address = 16'(16'h0100 + i);
            boot_data    = 8'(i);
            #4;
            check("reboot_write", {7'd0, mem_we, mem_address, mem_din},
                  {7'd0, 1'b1, 16'(16'h0100 + i), 8'(i)});
        end
        cyc();
        booting = 1'b0;
        #4;
        check("reb_t0_mem_we", 32'(mem_we), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            booting = (k == 3);
            #4;
            check("release_mem_we", 32'(mem_we), 32'd0);
            check("release_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        cyc();
        booting      = 1'b1;
        boot_address = 16'h0200;
        boot_data    = 8'h5C;
        #4;
        check("reassert_write", {7'd0, mem_we, mem_address, mem_din}, {7'd0, 1'b1, 16'h0200, 8'h5C});
        check("reassert_cpu_reset", 32'(cpu_reset), 32'd1);
        cyc();
        booting = 1'b0;
        #4;
        check("reassert_t0_mem_we", 32'(mem_we), 32'd0);
        release_check("rel2");

        // reset mid-S_BOOT
        cyc();
        reset = 1'b1;
        cyc();
        reset   = 1'b0;
        booting = 1'b1;
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        #4;
        check("midboot_reset_mem_we", 32'(mem_we), 32'd0);
        cyc();
        reset        = 1'b0;
        booting      = 1'b0;
        boot_address = 16'h0333;
        cpu_address  = 16'h0444;
        cpu_we       = 1'b1;
        #4;
        check("post_reset_cpu_reset", 32'(cpu_reset), 32'd1);
        check("post_reset_mem_we", 32'(mem_we), 32'd0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            #4;
            check("post_reset_hold", {15'd0, cpu_reset, mem_address}, {15'd0, 1'b1, 16'h0333});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
